regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 16 x 32-bit register file between two writeback requesters: A (ALU writeback) and B (load / multi-cycle unit). It arbitrates round-robin and registers the winning write into the register file's `RegWrite`/`Write_Reg`/`Write_Data` inputs. It can optionally track pending writes per register so issue logic can detect read-after-write hazards.

## Interface

Parameters:
- `NREGS`, default 16: number of architectural registers. Indices at or above `NREGS` are illegal.
- `AW`, default 5: register index width, matching the register file address ports.
- `DW`, default 32: data width.

Ports:
- `Clk`, in, 1: the single clock. All state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset. Asserted when 0.
- `Hold`, in, 1: when 1, no grants are issued. The output stage still drains.
- `A_Valid`, in, 1: requester A has a write pending.
- `A_Ready`, out, 1: A's write is accepted this cycle.
- `A_Reg`, in, AW: destination register index for A.
- `A_Data`, in, DW: write data for A.
- `B_Valid`, `B_Ready`, `B_Reg`, `B_Data`: same as the A ports, for requester B.
- `RegWrite`, out, 1: write enable to the register file.
- `Write_Reg`, out, AW: write address to the register file.
- `Write_Data`, out, DW: write data to the register file.
- `Err`, out, 1: sticky flag. Set when an illegal register index is accepted.
- `Query_Reg`, in, AW: register being checked for a hazard. Present only with `REGARB_SCOREBOARD_EN`.
- `Query_Busy`, out, 1: a write to `Query_Reg` is still pending. Present only with `REGARB_SCOREBOARD_EN`.
- `Busy_Vec`, out, NREGS: the full pending-write vector. Present only with `REGARB_SCOREBOARD_EN`.

## Operation

- **Handshake:**
  - A transfer occurs on a rising edge where `X_Valid && X_Ready`.
  - A requester holds its `Reg`/`Data` stable while `Valid` is high and not yet accepted.
  - `Ready` depends combinationally on both `Valid` inputs, `Hold` and the `Last` state bit. It never depends on the requester's own data.
- **Grant rules:**
  - `Hold`=1: neither `Ready` asserts.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - At most one `Ready` is high per cycle.
- **Round-robin state:** one bit, `Last`, which is 0 for A and 1 for B.
  - Updated on every accepted transfer.
  - Resets to 1, so A wins the first contested cycle.
- **Output stage:** one register holding `RegWrite`, `Write_Reg` and `Write_Data`.
  - On an accepted transfer with index < `NREGS`: loaded with `RegWrite`=1 and the granted requester's index and data.
  - On a cycle with no transfer: `RegWrite` goes to 0. `Write_Reg` and `Write_Data` hold their previous values.
  - The register file consumes one write per edge, so the stage never back-pressures.
- **Illegal index (index ≥ `NREGS`):**
  - The transfer is still accepted (`Ready` high).
  - `RegWrite` stays 0 on the following cycle.
  - `Err` is set. It clears only on reset.
- **Special registers:** writes to R14 (stack pointer) and R15 (return address) are legal and get no special treatment.
- **Same register from both requesters:** the writes are serialised by the grant order. The last one granted determines the final register contents.

## Timing

- **Reset values** (immediately on reset assertion): `RegWrite`=0, `Write_Reg`=0, `Write_Data`=0, `Err`=0, `Last`=1, `Busy_Vec`=0. `A_Ready` and `B_Ready` are low while reset is asserted.
- **Latency:** a transfer accepted at edge N drives `RegWrite`=1 during cycle N+1. The register file stores the data at edge N+1.
- **Throughput:** one write per cycle, sustained.
  - Both requesters continuously valid: grants alternate A, B, A, B, …
- **Reset mid-operation:** the in-flight output-stage write is discarded. `RegWrite` drops asynchronously. No partial write occurs.
- **Scoreboard timing** (with `REGARB_SCOREBOARD_EN`):
  - Bit r of `Busy_Vec` is set at edge N when a legal write to r is accepted.
  - It is cleared at edge N+1, when the write commits.
  - If r is accepted again at edge N+1, set wins and the bit stays 1.
  - `Query_Busy` = `Busy_Vec[Query_Reg]`, combinational. It is 0 for an out-of-range `Query_Reg`.

## Configuration

- Macro: `REGARB_SCOREBOARD_EN`.
- **Defined:** the `Busy_Vec` register, the `Query_Reg`/`Query_Busy` ports and the scoreboard logic are compiled in.
- **Undefined:** those ports and that logic are absent. Arbitration, the output stage and `Err` behave identically in both cases.

## Structure

- **Shared package** (`regfile_pkg`) holds:
  - `NREGS`, `AW`, `DW`.
  - The special-register indices: `REG_SP` = 14, `REG_RA` = 15.
  - The stack-pointer reset value 32'h1000, for use by the register file and its neighbours.
  - The requester-ID encoding (`REQ_A` = 0, `REQ_B` = 1).
- **Sub-module:** `rr_arbiter2`, a two-way round-robin grant with `Last` state and a hold input. It is instantiated once. The output stage and scoreboard stay in the top module.

## Test plan

- **Single requester:** `A_Valid`=1, `A_Reg`=3, `A_Data`=32'hDEAD_BEEF for one cycle → `A_Ready`=1. The next cycle shows `RegWrite`=1, `Write_Reg`=3, `Write_Data`=32'hDEADBEEF. The cycle after shows `RegWrite`=0.
- **Contention:** both requesters valid for 4 cycles (A to R1, B to R2) straight out of reset → grant order A, B, A, B. `Write_Reg` sequence is 1, 2, 1, 2, with no idle cycle.
- **Same destination:** A writes 32'h1 and B writes 32'h2, both to R5, contended → A commits first, then B. R5 ends at 32'h2.
- **Illegal index:** `B_Reg`=20 → `B_Ready`=1. `RegWrite` stays 0. `Err`=1 and remains 1 until `Reset`=0.
- **Hold and reset:**
  - `Hold`=1 with both requesters valid for 3 cycles → no `Ready`. The grant on release goes to A.
  - Pulse `Reset`=0 while `RegWrite`=1 → `RegWrite` drops immediately and `Busy_Vec`=0.
- **Scoreboard** (`REGARB_SCOREBOARD_EN` defined): accept a write to R7, with `Query_Reg`=7 → `Query_Busy`=1 for exactly one cycle. Back-to-back writes to R7 → `Query_Busy` stays 1 across both cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants: geometry, special register indices and requester IDs.
package regfile_pkg;

    localparam int NREGS = 16;
    localparam int AW    = 5;
    localparam int DW    = 32;

    localparam logic [AW-1:0] REG_SP = 5'd14;
    localparam logic [AW-1:0] REG_RA = 5'd15;

    localparam logic [DW-1:0] SP_RESET_VAL = 32'h0000_1000;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // True when idx names an implemented architectural register.
    function automatic logic reg_is_legal(input logic [AW-1:0] idx);
        return 32'(idx) < NREGS;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus: two requester handshakes plus the register-file write port.
interface regfile_write_arbiter_if #(
    parameter int AW = regfile_pkg::AW,
    parameter int DW = regfile_pkg::DW
);
    import regfile_pkg::*;

    logic          A_Valid;
    logic          A_Ready;
    logic [AW-1:0] A_Reg;
    logic [DW-1:0] A_Data;

    logic          B_Valid;
    logic          B_Ready;
    logic [AW-1:0] B_Reg;
    logic [DW-1:0] B_Data;

    logic          RegWrite;
    logic [AW-1:0] Write_Reg;
    logic [DW-1:0] Write_Data;

    modport master (
        output A_Valid, A_Reg, A_Data,
        output B_Valid, B_Reg, B_Data,
        input  A_Ready, B_Ready,
        input  RegWrite, Write_Reg, Write_Data
    );

    modport slave (
        input  A_Valid, A_Reg, A_Data,
        input  B_Valid, B_Reg, B_Data,
        output A_Ready, B_Ready,
        output RegWrite, Write_Reg, Write_Data
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with hold; grants are the requesters' Ready signals.
//
//   state  | meaning
//   REQ_A  | A was granted most recently, B wins the next contested cycle
//   REQ_B  | B was granted most recently (reset), A wins the next contested cycle
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic hold_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);
    import regfile_pkg::*;

    req_id_e last_q;
    req_id_e last_d;

    // Grants are gated by reset so neither requester sees Ready during reset.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (rst_n_i && !hold_i) begin
            gnt_a_o = req_a_i && (!req_b_i || (last_q == REQ_B));
            gnt_b_o = req_b_i && (!req_a_i || (last_q == REQ_A));
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_a_o) begin
            last_d = REQ_A;
        end else if (gnt_b_o) begin
            last_d = REQ_B;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two writeback requesters.
// Optional pending-write scoreboard enabled by REGARB_SCOREBOARD_EN.
module regfile_write_arbiter #(
    parameter int NREGS = regfile_pkg::NREGS,
    parameter int AW    = regfile_pkg::AW,
    parameter int DW    = regfile_pkg::DW
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Hold,
    regfile_write_arbiter_if.slave  bus,
`ifdef REGARB_SCOREBOARD_EN
    input  logic [AW-1:0]           Query_Reg,
    output logic                    Query_Busy,
    output logic [NREGS-1:0]        Busy_Vec,
`endif
    output logic                    Err
);
    import regfile_pkg::*;

    logic          gnt_a;
    logic          gnt_b;
    logic          xfer;
    logic [AW-1:0] sel_reg;
    logic [DW-1:0] sel_data;
    logic          sel_legal;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] wreg_q,     wreg_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          err_q,      err_d;

    rr_arbiter2 u_arb (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .hold_i  (Hold),
        .req_a_i (bus.A_Valid),
        .req_b_i (bus.B_Valid),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign bus.A_Ready = gnt_a;
    assign bus.B_Ready = gnt_b;

    always_comb begin
        xfer      = gnt_a | gnt_b;
        sel_reg   = gnt_b ? bus.B_Reg  : bus.A_Reg;
        sel_data  = gnt_b ? bus.B_Data : bus.A_Data;
        sel_legal = 32'(sel_reg) < NREGS;
    end

    // Illegal indices are accepted and dropped; address/data hold on any non-write.
    always_comb begin
        regwrite_d = xfer && sel_legal;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        err_d      = err_q | (xfer && !sel_legal);
        if (xfer && sel_legal) begin
            wreg_d  = sel_reg;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.RegWrite   = regwrite_q;
    assign bus.Write_Reg  = wreg_q;
    assign bus.Write_Data = wdata_q;
    assign Err            = err_q;

`ifdef REGARB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] commit_mask;

    // A bit clears when its write commits unless a new write to it is accepted the same edge.
    always_comb begin
        set_mask    = '0;
        commit_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            set_mask[i]    = regwrite_d && (32'(sel_reg) == i);
            commit_mask[i] = regwrite_q && (32'(wreg_q) == i);
        end
        busy_d = (busy_q & ~commit_mask) | set_mask;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        Query_Busy = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (32'(Query_Reg) == i) begin
                Query_Busy = busy_q[i];
            end
        end
    end

    assign Busy_Vec = busy_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter with a queue of expected writes.
module tb_regfile_write_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    logic Clk;
    logic Reset;
    logic Hold;
    logic Err;
    logic [AW-1:0] qreg;
`ifdef REGARB_SCOREBOARD_EN
    logic             Query_Busy;
    logic [NREGS-1:0] Busy_Vec;
`endif

    regfile_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Hold      (Hold),
        .bus       (bus),
`ifdef REGARB_SCOREBOARD_EN
        .Query_Reg (qreg),
        .Query_Busy(Query_Busy),
        .Busy_Vec  (Busy_Vec),
`endif
        .Err       (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic          last_m;
    logic          err_m;
    logic [AW-1:0] hold_reg_m;
    logic [DW-1:0] hold_data_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_m      = 1'b1;
        err_m       = 1'b0;
        hold_reg_m  = '0;
        hold_data_m = '0;
        q.delete();
    endtask

    task automatic idle_inputs();
        bus.A_Valid = 1'b0; bus.A_Reg = '0; bus.A_Data = '0;
        bus.B_Valid = 1'b0; bus.B_Reg = '0; bus.B_Data = '0;
        Hold = 1'b0;
    endtask

    // Pull reset while the design may be mid-write; outputs must clear without a clock edge.
    task automatic reset_pulse(input string tag);
        Reset = 1'b0;
        #1;
        chk({tag, "_regwrite"}, 64'(bus.RegWrite),   64'(0));
        chk({tag, "_wreg"},     64'(bus.Write_Reg),  64'(0));
        chk({tag, "_wdata"},    64'(bus.Write_Data), 64'(0));
        chk({tag, "_err"},      64'(Err),            64'(0));
        chk({tag, "_ready"},    64'({bus.A_Ready, bus.B_Ready}), 64'(0));
`ifdef REGARB_SCOREBOARD_EN
        chk({tag, "_busyvec"},  64'(Busy_Vec),       64'(0));
`endif
        model_reset();
        idle_inputs();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    // One clock of stimulus: drive, check Ready against the model, queue the
    // expected write, then compare the output stage after the edge.
    task automatic step(input string tag,
                        input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                        input logic hd, output logic ga, output logic gb);
        exp_t e, got;
        logic [AW-1:0] sr;
        logic [DW-1:0] sd;
        bus.A_Valid = av; bus.A_Reg = ar; bus.A_Data = ad;
        bus.B_Valid = bv; bus.B_Reg = br; bus.B_Data = bd;
        Hold = hd;
        ga = !hd && av && (!bv || last_m);
        gb = !hd && bv && (!av || !last_m);
        #1;
        chk({tag, "_a_ready"}, 64'(bus.A_Ready), 64'(ga));
        chk({tag, "_b_ready"}, 64'(bus.B_Ready), 64'(gb));
        sr = gb ? br : ar;
        sd = gb ? bd : ad;
        e.we = 1'b0;
        if (ga || gb) begin
            last_m = gb;
            if (int'(sr) < NREGS) begin
                e.we        = 1'b1;
                hold_reg_m  = sr;
                hold_data_m = sd;
            end else begin
                err_m = 1'b1;
            end
        end
        e.r = hold_reg_m;
        e.d = hold_data_m;
        q.push_back(e);
        @(posedge Clk);
        #1;
        got = q.pop_front();
        chk({tag, "_regwrite"}, 64'(bus.RegWrite),   64'(got.we));
        chk({tag, "_wreg"},     64'(bus.Write_Reg),  64'(got.r));
        chk({tag, "_wdata"},    64'(bus.Write_Data), 64'(got.d));
        chk({tag, "_err"},      64'(Err),            64'(err_m));
`ifdef REGARB_SCOREBOARD_EN
        chk({tag, "_busyvec"},   64'(Busy_Vec),
            got.we ? (64'(1) << got.r) : 64'(0));
        chk({tag, "_querybusy"}, 64'(Query_Busy), 64'(got.we && (got.r == qreg)));
`endif
    endtask

    initial begin
        logic ga, gb;
        logic av, bv;
        logic [AW-1:0] ar, br;
        logic [DW-1:0] ad, bd;

        qreg = 5'd7;
        model_reset();
        idle_inputs();
        bus.A_Valid = 1'b1;
        bus.B_Valid = 1'b1;
        Reset = 1'b0;
        #2;
        chk("rst_regwrite", 64'(bus.RegWrite),   64'(0));
        chk("rst_wreg",     64'(bus.Write_Reg),  64'(0));
        chk("rst_wdata",    64'(bus.Write_Data), 64'(0));
        chk("rst_err",      64'(Err),            64'(0));
        chk("rst_ready",    64'({bus.A_Ready, bus.B_Ready}), 64'(0));
        idle_inputs();
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Single requester, then idle.
        step("single", 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("single_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);

        // Reset while a write is in the output stage.
        step("pre_rst", 1'b1, 5'd9, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        reset_pulse("mid_rst");

        // Contention from reset: A, B, A, B back to back.
        for (int i = 0; i < 4; i++)
            step("contend", 1'b1, 5'd1, 32'hAAAA_0000 + 32'(i),
                 1'b1, 5'd2, 32'hBBBB_0000 + 32'(i), 1'b0, ga, gb);

        // Hold blocks both; release goes to A since B was granted last.
        for (int i = 0; i < 3; i++)
            step("hold", 1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h6666, 1'b1, ga, gb);
        step("hold_rel", 1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h6666, 1'b0, ga, gb);
        chk("hold_rel_winner_a", 64'(bus.Write_Reg), 64'(4));

        // Same destination from both: A then B, R5 ends at 2.
        reset_pulse("rst2");
        step("same_dst", 1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, 1'b0, ga, gb);
        step("same_dst2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h2, 1'b0, ga, gb);
        chk("same_dst_final", 64'(bus.Write_Data), 64'(32'h2));

        // Special registers are ordinary writes.
        step("sp", 1'b1, 5'd14, 32'h0000_1000, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("ra", 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hCAFE_F00D, 1'b0, ga, gb);

        // Illegal index: accepted, no write, sticky error until reset.
        step("illegal", 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h5555, 1'b0, ga, gb);
        step("illegal_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("illegal_ok", 1'b1, 5'd8, 32'h8888, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("illegal_16", 1'b1, 5'd16, 32'h1616, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        reset_pulse("rst3");

`ifdef REGARB_SCOREBOARD_EN
        // Single write to R7 is busy for exactly one cycle; back-to-back keeps it busy.
        step("sb_one", 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("sb_one_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("sb_b2b_a", 1'b1, 5'd7, 32'h7001, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        step("sb_b2b_b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7002, 1'b0, ga, gb);
        step("sb_b2b_idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        qreg = 5'd20;
        step("sb_oor", 1'b1, 5'd20, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ga, gb);
        qreg = 5'd7;
        reset_pulse("rst4");
`endif

        // Random traffic; a requester keeps Reg/Data stable until accepted.
        av = 1'b0; bv = 1'b0; ar = '0; br = '0; ad = '0; bd = '0;
        for (int i = 0; i < 40; i++) begin
            if (!av) begin
                av = 1'($urandom_range(0, 1));
                ar = AW'($urandom_range(0, 17));
                ad = $urandom;
            end
            if (!bv) begin
                bv = 1'($urandom_range(0, 1));
                br = AW'($urandom_range(0, 17));
                bd = $urandom;
            end
            qreg = ar;
            step("rand", av, ar, ad, bv, br, bd, 1'($urandom_range(0, 3) == 0), ga, gb);
            if (ga) av = 1'b0;
            if (gb) bv = 1'b0;
        end
        idle_inputs();
        reset_pulse("rst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
